// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: data/address widths, architectural register
// indices and the stack-pointer reset value.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [DATA_W-1:0] SP_RESET = 32'h0000_3FFC;

endpackage

// File: rtl/banco_registradores.sv
// MIPS register file: 32 x 32-bit, two combinational read ports, one debug read
// port, one synchronous write port. Define REGFILE_BYPASS_EN for write-through
// forwarding on read_data1/read_data2 (dbg_data is never forwarded).
module banco_registradores
  import mips_pkg::*;
#(
  parameter int                   DATA_W   = mips_pkg::DATA_W,
  parameter int                   ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]    SP_RESET = mips_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[write_reg] = write_data;
    end
  end

  // Reset wins over any write presented at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic fwd;
`ifdef REGFILE_BYPASS_EN
    assign fwd = wr_en && (write_reg == rd_addr[p]);
`else
    assign fwd = 1'b0;
`endif
    assign rd_data[p] = (rd_addr[p] == '0) ? '0
                      : fwd                ? write_data
                      :                      regs_q[rd_addr[p]];
  end

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];
  assign dbg_data   = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: directed scenarios plus random
// traffic checked against an array model of the architectural registers.
module tb_banco_registradores;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
  logic [31:0] write_data;
  logic [31:0] read_data1, read_data2, dbg_data;

  int vectors;
  int miscompares;

  logic [31:0] model [32];

  banco_registradores dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[29] = 32'h0000_3FFC;
  endfunction

  // Architectural view of a read: r0 is zero, ports may see the pending write.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit is_port);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (is_port && reg_write && write_reg != 5'd0 && write_reg == a) return write_data;
`endif
    return model[a];
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (reg_write && write_reg != 5'd0) model[write_reg] = write_data;
    #1;
  endtask

  task automatic test_reset();
    reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      vectors++;
      if (dbg_data !== ((a == 29) ? 32'h0000_3FFC : 32'd0)) begin
        miscompares++;
        $display("FAIL reset_state reg%0d got %h want %h", a, dbg_data,
                 (a == 29) ? 32'h0000_3FFC : 32'd0);
      end
    end
  endtask

  task automatic test_basic();
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEAD_BEEF;
    step();
    reg_write = 1'b0; read_reg1 = 5'd8; write_data = 32'd1;
    #1;
    vectors++;
    if (read_data1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL basic_write got %h want %h", read_data1, 32'hDEAD_BEEF);
    end
    step();
    vectors++;
    if (read_data1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL basic_no_write got %h want %h", read_data1, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_zero();
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
    read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_addr = 5'd0;
    step();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (read_data1 !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_rd1 got %h want %h", read_data1, 32'd0);
    end
    vectors++;
    if (read_data2 !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_rd2 got %h want %h", read_data2, 32'd0);
    end
    vectors++;
    if (dbg_data !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_dbg got %h want %h", dbg_data, 32'd0);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] want_pre;
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'd5;
    step();
    write_data = 32'd7; read_reg2 = 5'd9;
`ifdef REGFILE_BYPASS_EN
    want_pre = 32'd7;
`else
    want_pre = 32'd5;
`endif
    #1;
    vectors++;
    if (read_data2 !== want_pre) begin
      miscompares++;
      $display("FAIL hazard_pre_edge got %h want %h", read_data2, want_pre);
    end
    step();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (read_data2 !== 32'd7) begin
      miscompares++;
      $display("FAIL hazard_post_edge got %h want %h", read_data2, 32'd7);
    end
  endtask

  task automatic test_reset_vs_write();
    reg_write = 1'b1; write_reg = 5'd10; write_data = 32'd3; dbg_addr = 5'd10;
    #2;
    rst_n = 1'b0;
    model_reset();
    step();
    #2;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (dbg_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_vs_write_held got %h want %h", dbg_data, 32'd0);
    end
    step();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (dbg_data !== 32'd3) begin
      miscompares++;
      $display("FAIL reset_vs_write_first got %h want %h", dbg_data, 32'd3);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] want;
    for (int i = 1; i < 32; i++) begin
      reg_write = 1'b1; write_reg = 5'(i); write_data = 32'(i * 4 + 1);
      step();
    end
    reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a); read_reg2 = 5'(a); dbg_addr = 5'(a);
      want = (a == 0) ? 32'd0 : 32'(a * 4 + 1);
      #1;
      vectors++;
      if (read_data1 !== want) begin
        miscompares++;
        $display("FAIL sweep_rd1 reg%0d got %h want %h", a, read_data1, want);
      end
      vectors++;
      if (read_data2 !== want) begin
        miscompares++;
        $display("FAIL sweep_rd2 reg%0d got %h want %h", a, read_data2, want);
      end
      vectors++;
      if (dbg_data !== want) begin
        miscompares++;
        $display("FAIL sweep_dbg reg%0d got %h want %h", a, dbg_data, want);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, ed;
    for (int n = 0; n < 400; n++) begin
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom();
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      dbg_addr   = 5'($urandom_range(0, 31));
      #1;
      e1 = exp_read(read_reg1, 1'b1);
      e2 = exp_read(read_reg2, 1'b1);
      ed = exp_read(dbg_addr, 1'b0);
      vectors++;
      if (read_data1 !== e1) begin
        miscompares++;
        $display("FAIL rand_rd1 n%0d addr%0d got %h want %h", n, read_reg1, read_data1, e1);
      end
      vectors++;
      if (read_data2 !== e2) begin
        miscompares++;
        $display("FAIL rand_rd2 n%0d addr%0d got %h want %h", n, read_reg2, read_data2, e2);
      end
      vectors++;
      if (dbg_data !== ed) begin
        miscompares++;
        $display("FAIL rand_dbg n%0d addr%0d got %h want %h", n, dbg_addr, dbg_data, ed);
      end
      step();
    end
    reg_write = 1'b0;
  endtask

  task automatic test_async_reset();
    reg_write = 1'b0; dbg_addr = 5'd8;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dbg_data !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset_r8 got %h want %h", dbg_data, 32'd0);
    end
    dbg_addr = 5'd29;
    #1;
    vectors++;
    if (dbg_data !== 32'h0000_3FFC) begin
      miscompares++;
      $display("FAIL async_reset_sp got %h want %h", dbg_data, 32'h0000_3FFC);
    end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      vectors++;
      if (dbg_data !== model[a]) begin
        miscompares++;
        $display("FAIL async_reset_all reg%0d got %h want %h", a, dbg_data, model[a]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; reg_write = 1'b0;
    read_reg1 = '0; read_reg2 = '0; write_reg = '0; dbg_addr = '0; write_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    step();
    test_basic();
    test_zero();
    test_hazard();
    test_reset_vs_write();
    test_sweep();
    test_random();
    step();
    test_async_reset();
    step();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
